instr_aligner: RTL
==================

INSTR_ALIGNER -- requirements
Module: instr_aligner

Interface
REQ-001 Parameter NUM_BLOCKS, default 4, SHALL set the halfword slots per fetch block.
REQ-002 Parameter NUM_OUT, default 2, SHALL set the instructions emitted per cycle.
REQ-003 Parameter BUF_ENTRIES, default 8 (power of two, >= 2*NUM_BLOCKS), SHALL set halfword buffer depth.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 IN_instrs  in  IF_Instr[NUM_BLOCKS]  fetch block: per slot instr[15:0], pc[30:0], valid, branchID[5:0], branchPred.
REQ-007 OUT_stall  out  1  fetch hold request; drives the fetch stage enables low.
REQ-008 IN_clear  in  1  flush on redirect or mispredict.
REQ-009 IN_ready  in  1  downstream accepts OUT_instrs this cycle.
REQ-010 OUT_instrs  out  PD_Instr[NUM_OUT]  instr[31:0], pc[30:0], compressed, branchID[5:0], branchPred, valid.

Function
REQ-011 OUT_stall SHALL be high when free buffer entries < NUM_BLOCKS, computed from registered count only.
REQ-012 When !OUT_stall and !IN_clear, valid slots SHALL be compacted in slot order and appended at tail; invalid slots SHALL consume no entry.
REQ-013 Entry SHALL store instr, pc, branchID, branchPred; head/tail pointers SHALL wrap modulo BUF_ENTRIES.
REQ-014 Extraction from head: halfword with instr[1:0] != 2'b11 SHALL form a 16-bit instruction (compressed=1, instr[31:16]=0).
REQ-015 Halfword with instr[1:0] == 2'b11 SHALL pair with the next entry as instr[31:16] (compressed=0); if the next entry is absent, extraction SHALL stop and the lower half SHALL remain buffered.
REQ-016 Output pc SHALL be the first halfword's pc; branchID/branchPred SHALL come from the last halfword of the instruction.
REQ-017 Up to NUM_OUT instructions SHALL be extracted per cycle, in program order, lowest output index first; extraction SHALL stop at the first incomplete instruction.
REQ-018 Output register SHALL load when IN_ready or no OUT_instrs entry is valid; otherwise it SHALL hold and extraction SHALL not pop.
REQ-019 Unfilled output slots SHALL have valid=0; valid outputs SHALL be packed from index 0.
REQ-020 Append and pop in the same cycle SHALL both occur; count SHALL update by appended minus popped.
REQ-021 Latency: a halfword presented in cycle t with room SHALL appear on OUT_instrs in cycle t+2 at the earliest.
REQ-022 IN_clear SHALL take priority: count=0, head=tail, all OUT_instrs valid=0 next cycle; that cycle's input SHALL be dropped.
REQ-023 A buffered lower half awaiting its upper half SHALL be discarded by IN_clear.
REQ-024 Count SHALL never exceed BUF_ENTRIES; a full buffer SHALL hold OUT_stall high until pops occur.

Reset
REQ-025 On rst low, immediately: count=0, head=0, tail=0, all OUT_instrs valid=0, OUT_stall=0.
REQ-026 Reset mid-operation SHALL discard all buffered and output contents; data fields need no reset value.
REQ-027 First append SHALL be accepted in the first cycle after rst deasserts.

Structure
REQ-028 IF_Instr and PD_Instr typedefs SHALL reside in the shared package; IF_Instr matches the fetch stage output.
REQ-029 Halfword FIFO (storage, pointers, count, multi-write compaction) SHALL be sub-module halfword_fifo; length decode and output register stay in instr_aligner.

Verification
REQ-030 Four valid compressed halfwords pc 0x100..0x103, IN_ready=1 -> cycle t+2 emits pc 0x100,0x101, cycle t+3 emits 0x102,0x103, all compressed=1.
REQ-031 Block with slot3 instr=0x0513 (low bits 11), next block slot0 instr=0x0000 -> single 32-bit instr 0x00000513, pc of slot3, compressed=0.
REQ-032 Block with valid=0,0,1,1 (pc 0x202,0x203), slot3 branchID=5, branchPred=1 -> two entries appended; instruction at 0x203 carries branchID 5, branchPred 1.
REQ-033 IN_ready=0 for 3 cycles with full blocks each cycle -> OUT_stall rises once free < 4; no halfword lost or duplicated after IN_ready returns.
REQ-034 IN_clear while a 32-bit lower half is buffered and a block is presented -> next cycle count=0, outputs invalid, OUT_stall=0.
REQ-035 rst low during stall with 8 entries buffered -> outputs invalid and OUT_stall=0 immediately; after release, a fresh block emits normally.

Source files
------------

// File: rtl/instr_aligner_pkg.sv
// Shared fetch/predecode types for the instruction aligner and its halfword buffer.
package instr_aligner_pkg;

   typedef struct packed {
      logic [15:0] instr;
      logic [30:0] pc;
      logic        valid;
      logic [5:0]  branchID;
      logic        branchPred;
   } IF_Instr;

   typedef struct packed {
      logic [31:0] instr;
      logic [30:0] pc;
      logic        compressed;
      logic [5:0]  branchID;
      logic        branchPred;
      logic        valid;
   } PD_Instr;

   typedef struct packed {
      logic [15:0] instr;
      logic [30:0] pc;
      logic [5:0]  branch_id;
      logic        branch_pred;
   } hw_entry_t;

   // A halfword whose low two bits are 11 is the lower half of a 32-bit instruction.
   function automatic logic is_wide(input logic [15:0] hw);
      return hw[1:0] == 2'b11;
   endfunction

endpackage

// File: rtl/instr_aligner_halfword_fifo.sv
// Circular halfword buffer: compacts the valid slots of a fetch block into the tail
// and exposes a window of entries starting at the head for decode.
module halfword_fifo
   import instr_aligner_pkg::*;
#(
   parameter  int NUM_BLOCKS  = 4,
   parameter  int BUF_ENTRIES = 8,
   parameter  int PEEK        = 4,
   localparam int CNT_W       = $clog2(BUF_ENTRIES) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  IF_Instr          in_instrs [NUM_BLOCKS],
   input  logic [CNT_W-1:0] pop_cnt,
   output logic [CNT_W-1:0] count,
   output hw_entry_t        peek [PEEK],
   output logic             stall
);

   localparam int PTR_W = $clog2(BUF_ENTRIES);

   hw_entry_t        mem [BUF_ENTRIES];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W-1:0] wr_idx [NUM_BLOCKS];
   logic [CNT_W-1:0] app_cnt;
   logic [CNT_W-1:0] app_eff;
   logic             wr_en;

   assign stall   = (CNT_W'(BUF_ENTRIES) - count) < CNT_W'(NUM_BLOCKS);
   assign wr_en   = !stall && !clear;
   assign app_eff = wr_en ? app_cnt : '0;

   // Each valid slot lands at tail plus the number of valid slots before it.
   always_comb begin
      app_cnt = '0;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
         wr_idx[i] = tail + PTR_W'(app_cnt);
         if (in_instrs[i].valid) app_cnt = app_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      for (int k = 0; k < PEEK; k++) peek[k] = mem[head + PTR_W'(k)];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (clear) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PTR_W'(pop_cnt);
         tail  <= tail + PTR_W'(app_eff);
         count <= count + app_eff - pop_cnt;
      end
   end

   // NOTE: storage is not reset; head, tail and count alone decide what is live.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < NUM_BLOCKS; i++) begin
            if (in_instrs[i].valid) begin
               mem[wr_idx[i]] <= '{instr:       in_instrs[i].instr,
                                   pc:          in_instrs[i].pc,
                                   branch_id:   in_instrs[i].branchID,
                                   branch_pred: in_instrs[i].branchPred};
            end
         end
      end
   end

endmodule

// File: rtl/instr_aligner.sv
// Aligns fetched halfwords into whole 16/32-bit instructions, up to NUM_OUT per
// cycle, behind a registered output stage.
module instr_aligner
   import instr_aligner_pkg::*;
#(
   parameter int NUM_BLOCKS  = 4,
   parameter int NUM_OUT     = 2,
   parameter int BUF_ENTRIES = 8
) (
   input  logic    clk,
   input  logic    rst,
   input  IF_Instr IN_instrs [NUM_BLOCKS],
   output logic    OUT_stall,
   input  logic    IN_clear,
   input  logic    IN_ready,
   output PD_Instr OUT_instrs [NUM_OUT]
);

   localparam int PEEK  = 2 * NUM_OUT;
   localparam int CNT_W = $clog2(BUF_ENTRIES) + 1;
   localparam int IDX_W = (PEEK > 1) ? $clog2(PEEK) : 1;

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] take_cnt;
   logic [CNT_W-1:0] pop_cnt;
   hw_entry_t        peek [PEEK];
   PD_Instr          nxt  [NUM_OUT];
   logic             out_any;
   logic             load;

   halfword_fifo #(
      .NUM_BLOCKS  (NUM_BLOCKS),
      .BUF_ENTRIES (BUF_ENTRIES),
      .PEEK        (PEEK)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (IN_clear),
      .in_instrs (IN_instrs),
      .pop_cnt   (pop_cnt),
      .count     (count),
      .peek      (peek),
      .stall     (OUT_stall)
   );

   // NOTE: blocking assignments here; pos and done are combinational scratch, not state.
   always_comb begin : decode
      int               pos;
      logic             done;
      logic [IDX_W-1:0] i0;
      logic [IDX_W-1:0] i1;
      pos  = 0;
      done = 1'b0;
      i0   = '0;
      i1   = '0;
      for (int o = 0; o < NUM_OUT; o++) begin
         nxt[o] = '0;
         i0     = IDX_W'(pos);
         i1     = IDX_W'(pos + 1);
         if (!done) begin
            if (pos >= int'(count)) begin
               done = 1'b1;
            end else if (!is_wide(peek[i0].instr)) begin
               nxt[o].instr      = {16'h0000, peek[i0].instr};
               nxt[o].pc         = peek[i0].pc;
               nxt[o].compressed = 1'b1;
               nxt[o].branchID   = peek[i0].branch_id;
               nxt[o].branchPred = peek[i0].branch_pred;
               nxt[o].valid      = 1'b1;
               pos = pos + 1;
            end else if (pos + 1 >= int'(count)) begin
               done = 1'b1;  // lower half stays buffered until its upper half arrives
            end else begin
               nxt[o].instr      = {peek[i1].instr, peek[i0].instr};
               nxt[o].pc         = peek[i0].pc;
               nxt[o].compressed = 1'b0;
               nxt[o].branchID   = peek[i1].branch_id;
               nxt[o].branchPred = peek[i1].branch_pred;
               nxt[o].valid      = 1'b1;
               pos = pos + 2;
            end
         end
      end
      take_cnt = CNT_W'(pos);
   end

   always_comb begin
      out_any = 1'b0;
      for (int o = 0; o < NUM_OUT; o++) out_any = out_any | OUT_instrs[o].valid;
   end

   assign load    = IN_ready || !out_any;
   assign pop_cnt = (load && !IN_clear) ? take_cnt : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int o = 0; o < NUM_OUT; o++) OUT_instrs[o] <= '0;
      end else if (IN_clear) begin
         for (int o = 0; o < NUM_OUT; o++) OUT_instrs[o] <= '0;
      end else if (load) begin
         for (int o = 0; o < NUM_OUT; o++) OUT_instrs[o] <= nxt[o];
      end
   end

endmodule
